// File: rtl/sc_frame_sng.sv
// sc_frame_sng: binary-to-stochastic frame transmitter with a one-entry holding register
module sc_frame_sng #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [WIDTH-1:0] rng,
  output logic             out,
  output logic             out_valid,
  output logic             out_last
);
  localparam int FRAME_LEN = 2**WIDTH;
  typedef enum logic {IDLE, STREAM} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] cur_val, bit_cnt, hold_val;
  logic hold_full, hs, frame_end;
  assign in_ready = !hold_full && !flush && !rst;
  assign hs = in_valid && in_ready;
  assign frame_end = (state == STREAM) && (bit_cnt == WIDTH'(FRAME_LEN - 1));
  // state register
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  // next state; a value caught in the hold at the very last bit is picked up from IDLE
  always_comb
    state_nx = flush ? IDLE :
               (state == IDLE) ? ((hs || hold_full) ? STREAM : IDLE) :
               (frame_end && !hold_full) ? IDLE : STREAM;
  // datapath: frame bits, bit counter, current and held values
  always_ff @(posedge clk)
    if (rst) begin
      cur_val <= '0;
      bit_cnt <= '0;
      hold_val <= '0;
      hold_full <= 1'b0;
      out <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end else if (flush) begin
      bit_cnt <= '0;
      hold_full <= 1'b0;
      out <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end else if (state == IDLE) begin
      out <= 1'b0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      bit_cnt <= '0;
      if (hold_full) begin
        cur_val <= hold_val;
        hold_full <= 1'b0;
      end else if (hs) cur_val <= in_data;
    end else begin
      out <= rng < cur_val;
      out_valid <= 1'b1;
      out_last <= frame_end;
      bit_cnt <= bit_cnt + 1'b1;
      if (hs) begin
        hold_val <= in_data;
        hold_full <= 1'b1;
      end
      if (frame_end && hold_full) begin
        cur_val <= hold_val;
        hold_full <= 1'b0;
      end
    end
endmodule

// File: tb/tb_sc_frame_sng.sv
// tb_sc_frame_sng: directed checks of the stochastic frame transmitter
module tb_sc_frame_sng;
  logic clk = 0, rst = 1, in_valid = 0, flush = 0;
  logic [7:0] in_data = 0, rng = 0;
  logic in_ready, out, out_valid, out_last;
  logic rng_cnt = 1;
  int checks = 0, passed = 0;
  int run = 0, ones_acc = 0;
  int q_ones[$], q_len[$];

  sc_frame_sng #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .rng(rng), .out(out), .out_valid(out_valid), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // sink model (plays the sd_converter): ones per frame and contiguous run length at each out_last
  always @(negedge clk)
    if (out_valid) begin
      run++;
      ones_acc += int'(out);
      if (out_last) begin
        q_ones.push_back(ones_acc);
        q_len.push_back(run);
        ones_acc = 0;
      end
    end else begin
      run = 0;
      ones_acc = 0;
    end

  task automatic step();
    @(posedge clk);
    #1;
    if (rng_cnt) rng = rng + 8'd1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [7:0] v);
    int t;
    in_data = v;
    in_valid = 1;
    #0;
    t = 0;
    while (!in_ready && t < 1000) begin
      step();
      t++;
    end
    checks++;
    if (!in_ready) $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    else passed++;
    step();
    in_valid = 0;
  endtask

  task automatic check_frames(input string name, input int exp_ones[$], input int exp_len[$]);
    checks++;
    if (q_ones.size() != exp_ones.size())
      $display("FAIL %s_count: frames=%0d required %0d", name, q_ones.size(), exp_ones.size());
    else passed++;
    for (int i = 0; i < exp_ones.size() && i < q_ones.size(); i++) begin
      checks++;
      if (q_ones[i] != exp_ones[i] || q_len[i] != exp_len[i])
        $display("FAIL %s_frame%0d: ones=%0d run=%0d required ones=%0d run=%0d",
                 name, i, q_ones[i], q_len[i], exp_ones[i], exp_len[i]);
      else passed++;
    end
    checks++;
    if (out_valid !== 1'b0) $display("FAIL %s_end: out_valid=%0b required 0", name, out_valid);
    else passed++;
    q_ones.delete();
    q_len.delete();
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1;
    steps(4);
    checks++;
    if ({out, out_valid, out_last, in_ready} !== 4'b0000)
      $display("FAIL reset_out: out/valid/last/ready=%b required 0000", {out, out_valid, out_last, in_ready});
    else passed++;
    rst = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_ready: in_ready=%0b required 1", in_ready);
    else passed++;
    for (int i = 0; i < 20; i++) begin
      step();
      if ({out, out_valid, out_last} !== 3'b000) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL idle_quiet: %0d nonzero cycles required 0", bad);
    else passed++;
  endtask

  task automatic test_single();
    rng_cnt = 1;
    send(8'd100);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL latency0: out_valid=%0b required 0", out_valid);
    else passed++;
    step();
    checks++;
    if (out_valid !== 1'b1) $display("FAIL latency1: out_valid=%0b required 1", out_valid);
    else passed++;
    steps(260);
    check_frames("single", '{100}, '{256});
  endtask

  task automatic test_back_to_back();
    send(8'd15);
    send(8'd200);
    checks++;
    if (in_ready !== 1'b0) $display("FAIL b2b_ready: in_ready=%0b required 0", in_ready);
    else passed++;
    steps(200);
    checks++;
    if (in_ready !== 1'b0 || q_ones.size() != 0)
      $display("FAIL b2b_hold: in_ready=%0b frames=%0d required 0 0", in_ready, q_ones.size());
    else passed++;
    steps(320);
    check_frames("b2b", '{15, 200}, '{256, 512});
  endtask

  task automatic test_boundaries();
    rng_cnt = 1;
    send(8'd0);
    steps(262);
    check_frames("val0", '{0}, '{256});
    send(8'd255);
    steps(262);
    check_frames("val255", '{255}, '{256});
    rng_cnt = 0;
    rng = 0;
    send(8'd0);
    steps(262);
    check_frames("rng0_val0", '{0}, '{256});
    send(8'd1);
    steps(262);
    check_frames("rng0_val1", '{256}, '{256});
    rng_cnt = 1;
  endtask

  task automatic test_flush();
    send(8'd90);
    send(8'd30);
    steps(49);
    flush = 1;
    step();
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0)
      $display("FAIL flush_out: valid=%0b last=%0b required 0 0", out_valid, out_last);
    else passed++;
    flush = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) $display("FAIL flush_ready: in_ready=%0b required 1", in_ready);
    else passed++;
    steps(300);
    checks++;
    if (q_ones.size() != 0 || out_valid !== 1'b0)
      $display("FAIL flush_drop: frames=%0d valid=%0b required 0 0", q_ones.size(), out_valid);
    else passed++;
    send(8'd64);
    steps(262);
    check_frames("after_flush", '{64}, '{256});
  endtask

  task automatic test_rst_e2e();
    send(8'd77);
    send(8'd33);
    steps(119);
    rst = 1;
    step();
    rst = 0;
    #1;
    checks++;
    if ({out, out_valid, out_last, in_ready} !== 4'b0001)
      $display("FAIL midrst: out/valid/last/ready=%b required 0001", {out, out_valid, out_last, in_ready});
    else passed++;
    steps(300);
    checks++;
    if (q_ones.size() != 0 || out_valid !== 1'b0)
      $display("FAIL midrst_drop: frames=%0d valid=%0b required 0 0", q_ones.size(), out_valid);
    else passed++;
    send(8'd10);
    send(8'd128);
    send(8'd240);
    steps(520);
    check_frames("e2e", '{10, 128, 240}, '{256, 512, 768});
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_boundaries();
    test_flush();
    test_rst_e2e();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
